// File: rtl/exu_pkg.sv
// exu_pkg: shared constants and EX/MEM register layout for the RV64 execute stage
package exu_pkg;

    localparam int XLEN = 64;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_MEM  = 3'd1;
    localparam logic [2:0] WB_LINK = 3'd2;

    typedef struct packed {
        logic [4:0]      index_rd;
        logic [4:0]      index_rs1;
        logic [4:0]      index_rs2;
        logic            jump_en;
        logic            branch_en;
        logic            branch_result;
        logic            load_en;
        logic            store_en;
        logic            wb_en;
        logic [XLEN-1:0] branch_pc;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] gpr_data2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_plus4;
        logic [2:0]      load_opcode;
        logic [3:0]      store_len;
        logic [2:0]      wb_choose;
    } ex_mem_t;

endpackage

// File: rtl/exu_alu.sv
// exu_alu: combinational RV64I ALU with W-op support; RV64M_EN adds multiply/divide
module exu_alu
    import exu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      opcode,
    input  logic            halfop,
    output logic [XLEN-1:0] result
);

    logic [5:0]      shamt;
    logic [XLEN-1:0] a_zx, a_sx, raw;

    assign shamt = halfop ? {1'b0, b[4:0]} : b[5:0];
    assign a_zx  = halfop ? {32'd0, a[31:0]} : a;
    assign a_sx  = halfop ? {{32{a[31]}}, a[31:0]} : a;

`ifdef RV64M_EN
    logic              a_sgn, b_sgn, div_sgn, div_zero, div_ovf;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dd, dv, dv_safe, q_s, q_u, r_s, r_u, quo, rem;

    assign a_sgn    = (opcode == ALU_MULH) || (opcode == ALU_MULHSU);
    assign b_sgn    = opcode == ALU_MULH;
    assign prod     = {{XLEN{a_sgn & a[XLEN-1]}}, a} * {{XLEN{b_sgn & b[XLEN-1]}}, b};
    assign div_sgn  = (opcode == ALU_DIV) || (opcode == ALU_REM);
    assign dd       = div_sgn ? a_sx : a_zx;
    assign dv       = !halfop ? b : div_sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    assign div_zero = dv == '0;
    assign div_ovf  = div_sgn & (dd == {1'b1, {(XLEN-1){1'b0}}}) & (&dv);
    // keep the divider away from /0 and MIN/-1; those cases are overridden below
    assign dv_safe  = (div_zero | div_ovf) ? {{(XLEN-1){1'b0}}, 1'b1} : dv;
    assign q_s      = $signed(dd) / $signed(dv_safe);
    assign r_s      = $signed(dd) % $signed(dv_safe);
    assign q_u      = dd / dv_safe;
    assign r_u      = dd % dv_safe;
    assign quo      = div_zero ? '1 : div_ovf ? dd : div_sgn ? q_s : q_u;
    assign rem      = div_zero ? dd : div_ovf ? '0 : div_sgn ? r_s : r_u;
`endif

    // operation select; W ops reuse the 64-bit paths on pre-extended operands
    always_comb begin
        raw = '0;
        case (opcode)
            ALU_ADD:    raw = a + b;
            ALU_SUB:    raw = a - b;
            ALU_SLL:    raw = a << shamt;
            ALU_SLT:    raw = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   raw = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:    raw = a ^ b;
            ALU_SRL:    raw = a_zx >> shamt;
            ALU_SRA:    raw = $signed(a_sx) >>> shamt;
            ALU_OR:     raw = a | b;
            ALU_AND:    raw = a & b;
            ALU_PASSB:  raw = b;
`ifdef RV64M_EN
            ALU_MUL:    raw = prod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  raw = prod[2*XLEN-1:XLEN];
            ALU_DIV,
            ALU_DIVU:   raw = quo;
            ALU_REM,
            ALU_REMU:   raw = rem;
`endif
            default:    raw = '0;
        endcase
    end

    assign result = halfop ? {{32{raw[31]}}, raw[31:0]} : raw;

endmodule

// File: rtl/exu_fwd_stage.sv
// exu_fwd_stage: RV64 execute stage with operand forwarding and EX/MEM register (RV64M_EN enables M ops in exu_alu)
module exu_fwd_stage
    import exu_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] idu_pc,
    input  logic [XLEN-1:0] idu_gpr_data1,
    input  logic [XLEN-1:0] idu_gpr_data2,
    input  logic [XLEN-1:0] idu_imm,
    input  logic [4:0]      idu_index_rs1,
    input  logic [4:0]      idu_index_rs2,
    input  logic [4:0]      idu_index_rd,
    input  logic [4:0]      idu_alu_opcode,
    input  logic            idu_alu_en,
    input  logic            idu_alu_imm_en,
    input  logic            idu_alu_pc_en,
    input  logic            idu_alu_halfop,
    input  logic [2:0]      idu_branch_opcode,
    input  logic            idu_jump_en,
    input  logic            idu_branch_en,
    input  logic            idu_load_en,
    input  logic            idu_store_en,
    input  logic            idu_wb_en,
    input  logic [2:0]      idu_load_opcode,
    input  logic [3:0]      idu_store_len,
    input  logic [2:0]      idu_wb_choose,
    input  logic [4:0]      mmu_index_rd,
    input  logic            mmu_wb_en,
    input  logic [XLEN-1:0] mmu_wb_data,
    input  logic            mmu_jump_en,
    input  logic            mmu_branch_en,
    output logic            flush_nop,
    output logic            fw_en1,
    output logic            fw_en2,
    output logic [4:0]      exu_index_rd,
    output logic [4:0]      exu_index_rs1,
    output logic [4:0]      exu_index_rs2,
    output logic            exu_jump_en,
    output logic            exu_branch_en,
    output logic            exu_branch_result,
    output logic            exu_load_en,
    output logic            exu_store_en,
    output logic            exu_wb_en,
    output logic [XLEN-1:0] exu_branch_pc,
    output logic [XLEN-1:0] exu_alu_result,
    output logic [XLEN-1:0] exu_gpr_data2,
    output logic [XLEN-1:0] exu_imm,
    output logic [XLEN-1:0] exu_pc_plus4,
    output logic [2:0]      exu_load_opcode,
    output logic [3:0]      exu_store_len,
    output logic [2:0]      exu_wb_choose
);

    ex_mem_t         d, q;
    logic            ex_ok, mem_ok, hit1_ex, hit1_mem, hit2_ex, hit2_mem, br_eq, br_lt, br_ltu, br_taken;
    logic [XLEN-1:0] ex_fwd, rs1_val, rs2_val, op_a, op_b, alu_raw, alu_result;

    assign flush_nop = mmu_jump_en | mmu_branch_en;

    // loads in EX/MEM have no data yet; load-use is stalled upstream
    assign ex_ok    = q.wb_en & ~q.load_en & (q.index_rd != 5'd0);
    assign mem_ok   = mmu_wb_en & (mmu_index_rd != 5'd0);
    assign ex_fwd   = (q.wb_choose == WB_LINK) ? q.pc_plus4 : q.alu_result;
    assign hit1_ex  = ex_ok & (q.index_rd == idu_index_rs1);
    assign hit2_ex  = ex_ok & (q.index_rd == idu_index_rs2);
    assign hit1_mem = mem_ok & (mmu_index_rd == idu_index_rs1);
    assign hit2_mem = mem_ok & (mmu_index_rd == idu_index_rs2);
    assign rs1_val  = hit1_ex ? ex_fwd : hit1_mem ? mmu_wb_data : idu_gpr_data1;
    assign rs2_val  = hit2_ex ? ex_fwd : hit2_mem ? mmu_wb_data : idu_gpr_data2;
    assign fw_en1   = hit1_ex | hit1_mem;
    assign fw_en2   = hit2_ex | hit2_mem;

    assign op_a = idu_alu_pc_en ? idu_pc : rs1_val;
    assign op_b = idu_alu_imm_en ? idu_imm : rs2_val;

    exu_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .opcode (idu_alu_opcode),
        .halfop (idu_alu_halfop),
        .result (alu_raw)
    );

    assign alu_result = idu_alu_en ? alu_raw : '0;

    assign br_eq    = rs1_val == rs2_val;
    assign br_lt    = $signed(rs1_val) < $signed(rs2_val);
    assign br_ltu   = rs1_val < rs2_val;
    assign br_taken = (idu_branch_opcode == BR_EQ)  ? br_eq   :
                      (idu_branch_opcode == BR_NE)  ? ~br_eq  :
                      (idu_branch_opcode == BR_LT)  ? br_lt   :
                      (idu_branch_opcode == BR_GE)  ? ~br_lt  :
                      (idu_branch_opcode == BR_LTU) ? br_ltu  :
                      (idu_branch_opcode == BR_GEU) ? ~br_ltu : 1'b0;

    // assemble the next EX/MEM contents
    always_comb begin
        d               = '0;
        d.index_rd      = idu_index_rd;
        d.index_rs1     = idu_index_rs1;
        d.index_rs2     = idu_index_rs2;
        d.jump_en       = idu_jump_en;
        d.branch_en     = idu_branch_en;
        d.branch_result = idu_branch_en & br_taken;
        d.load_en       = idu_load_en;
        d.store_en      = idu_store_en;
        d.wb_en         = idu_wb_en;
        d.branch_pc     = idu_jump_en ? (alu_result & ~64'd1) : idu_pc + idu_imm;
        d.alu_result    = alu_result;
        d.gpr_data2     = rs2_val;
        d.imm           = idu_imm;
        d.pc_plus4      = idu_pc + 64'd4;
        d.load_opcode   = idu_load_opcode;
        d.store_len     = idu_store_len;
        d.wb_choose     = idu_wb_choose;
    end

    // EX/MEM register; a flush loads an all-zero bubble
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)
            q <= '0;
        else
            q <= flush_nop ? '0 : d;
    end

    assign exu_index_rd      = q.index_rd;
    assign exu_index_rs1     = q.index_rs1;
    assign exu_index_rs2     = q.index_rs2;
    assign exu_jump_en       = q.jump_en;
    assign exu_branch_en     = q.branch_en;
    assign exu_branch_result = q.branch_result;
    assign exu_load_en       = q.load_en;
    assign exu_store_en      = q.store_en;
    assign exu_wb_en         = q.wb_en;
    assign exu_branch_pc     = q.branch_pc;
    assign exu_alu_result    = q.alu_result;
    assign exu_gpr_data2     = q.gpr_data2;
    assign exu_imm           = q.imm;
    assign exu_pc_plus4      = q.pc_plus4;
    assign exu_load_opcode   = q.load_opcode;
    assign exu_store_len     = q.store_len;
    assign exu_wb_choose     = q.wb_choose;

endmodule

// File: tb/tb_exu_fwd_stage.sv
// tb_exu_fwd_stage: directed vectors with a queue scoreboard for exu_fwd_stage
module tb_exu_fwd_stage;
    import exu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] idu_pc, idu_gpr_data1, idu_gpr_data2, idu_imm, mmu_wb_data;
    logic [4:0]  idu_index_rs1, idu_index_rs2, idu_index_rd, idu_alu_opcode, mmu_index_rd;
    logic        idu_alu_en, idu_alu_imm_en, idu_alu_pc_en, idu_alu_halfop;
    logic [2:0]  idu_branch_opcode, idu_load_opcode, idu_wb_choose;
    logic        idu_jump_en, idu_branch_en, idu_load_en, idu_store_en, idu_wb_en;
    logic [3:0]  idu_store_len;
    logic        mmu_wb_en, mmu_jump_en, mmu_branch_en;
    logic        flush_nop, fw_en1, fw_en2;
    logic [4:0]  exu_index_rd, exu_index_rs1, exu_index_rs2;
    logic        exu_jump_en, exu_branch_en, exu_branch_result, exu_load_en, exu_store_en, exu_wb_en;
    logic [63:0] exu_branch_pc, exu_alu_result, exu_gpr_data2, exu_imm, exu_pc_plus4;
    logic [2:0]  exu_load_opcode, exu_wb_choose;
    logic [3:0]  exu_store_len;

    typedef struct {
        logic [63:0] alu, bpc, pc4, g2;
        logic        wb, st;
        logic [4:0]  rd;
        int          br;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_bad = 0;

    exu_fwd_stage dut (
        .clk(clk), .rstn(rstn),
        .idu_pc(idu_pc), .idu_gpr_data1(idu_gpr_data1), .idu_gpr_data2(idu_gpr_data2), .idu_imm(idu_imm),
        .idu_index_rs1(idu_index_rs1), .idu_index_rs2(idu_index_rs2), .idu_index_rd(idu_index_rd),
        .idu_alu_opcode(idu_alu_opcode), .idu_alu_en(idu_alu_en), .idu_alu_imm_en(idu_alu_imm_en),
        .idu_alu_pc_en(idu_alu_pc_en), .idu_alu_halfop(idu_alu_halfop), .idu_branch_opcode(idu_branch_opcode),
        .idu_jump_en(idu_jump_en), .idu_branch_en(idu_branch_en), .idu_load_en(idu_load_en),
        .idu_store_en(idu_store_en), .idu_wb_en(idu_wb_en), .idu_load_opcode(idu_load_opcode),
        .idu_store_len(idu_store_len), .idu_wb_choose(idu_wb_choose),
        .mmu_index_rd(mmu_index_rd), .mmu_wb_en(mmu_wb_en), .mmu_wb_data(mmu_wb_data),
        .mmu_jump_en(mmu_jump_en), .mmu_branch_en(mmu_branch_en),
        .flush_nop(flush_nop), .fw_en1(fw_en1), .fw_en2(fw_en2),
        .exu_index_rd(exu_index_rd), .exu_index_rs1(exu_index_rs1), .exu_index_rs2(exu_index_rs2),
        .exu_jump_en(exu_jump_en), .exu_branch_en(exu_branch_en), .exu_branch_result(exu_branch_result),
        .exu_load_en(exu_load_en), .exu_store_en(exu_store_en), .exu_wb_en(exu_wb_en),
        .exu_branch_pc(exu_branch_pc), .exu_alu_result(exu_alu_result), .exu_gpr_data2(exu_gpr_data2),
        .exu_imm(exu_imm), .exu_pc_plus4(exu_pc_plus4), .exu_load_opcode(exu_load_opcode),
        .exu_store_len(exu_store_len), .exu_wb_choose(exu_wb_choose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear();
        idu_pc = '0; idu_gpr_data1 = '0; idu_gpr_data2 = '0; idu_imm = '0;
        idu_index_rs1 = '0; idu_index_rs2 = '0; idu_index_rd = '0; idu_alu_opcode = '0;
        idu_alu_en = 0; idu_alu_imm_en = 0; idu_alu_pc_en = 0; idu_alu_halfop = 0;
        idu_branch_opcode = '0; idu_load_opcode = '0; idu_wb_choose = '0; idu_store_len = '0;
        idu_jump_en = 0; idu_branch_en = 0; idu_load_en = 0; idu_store_en = 0; idu_wb_en = 0;
        mmu_index_rd = '0; mmu_wb_en = 0; mmu_wb_data = '0; mmu_jump_en = 0; mmu_branch_en = 0;
    endtask

    task automatic step();
        @(negedge clk);
        clear();
    endtask

    task automatic set_alu(input logic [4:0] op, input logic [4:0] rs1, input logic [63:0] g1,
                           input logic [63:0] imm, input logic [4:0] rd, input logic wb);
        idu_alu_en = 1; idu_alu_imm_en = 1; idu_alu_opcode = op;
        idu_index_rs1 = rs1; idu_gpr_data1 = g1; idu_imm = imm; idu_index_rd = rd; idu_wb_en = wb;
    endtask

    // br < 0 means branch_result is not meaningful for this vector
    task automatic push(input logic [63:0] alu, input logic [63:0] bpc, input logic [63:0] g2,
                        input int br, input bit fl);
        exp_t e;
        e.alu = alu; e.bpc = bpc; e.g2 = g2;
        e.br  = fl ? 0 : br;
        e.pc4 = fl ? 64'd0 : idu_pc + 64'd4;
        e.wb  = fl ? 1'b0 : idu_wb_en;
        e.st  = fl ? 1'b0 : idu_store_en;
        e.rd  = fl ? 5'd0 : idu_index_rd;
        sb.push_back(e);
    endtask

    // monitor: one EX/MEM result per cycle after each rising edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("alu_result", exu_alu_result, mon_e.alu);
            chk("branch_pc", exu_branch_pc, mon_e.bpc);
            chk("pc_plus4", exu_pc_plus4, mon_e.pc4);
            chk("gpr_data2", exu_gpr_data2, mon_e.g2);
            chk("wb_en", 64'(exu_wb_en), 64'(mon_e.wb));
            chk("store_en", 64'(exu_store_en), 64'(mon_e.st));
            chk("index_rd", 64'(exu_index_rd), 64'(mon_e.rd));
            if (mon_e.br >= 0) chk("branch_result", 64'(exu_branch_result), 64'(mon_e.br));
        end
    end

    initial begin
        rstn = 1;
        clear();
        idu_pc = {$urandom, $urandom}; idu_gpr_data1 = {$urandom, $urandom}; idu_imm = {$urandom, $urandom};
        idu_alu_opcode = 5'($urandom_range(0, 10)); idu_alu_en = 1; idu_wb_en = 1; idu_store_en = 1;
        idu_index_rd = 5'($urandom_range(1, 31)); idu_branch_en = 1; idu_jump_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alu", exu_alu_result, 0);
        chk("rst_pc4", exu_pc_plus4, 0);
        chk("rst_bpc", exu_branch_pc, 0);
        chk("rst_imm", exu_imm, 0);
        chk("rst_wb", 64'(exu_wb_en), 0);
        chk("rst_st", 64'(exu_store_en), 0);
        chk("rst_rd", 64'(exu_index_rd), 0);
        chk("rst_jump", 64'(exu_jump_en), 0);
        mmu_jump_en = 1; #1 chk("flush_jump", 64'(flush_nop), 1);
        mmu_jump_en = 0; #1 chk("flush_idle", 64'(flush_nop), 0);
        mmu_branch_en = 1; #1 chk("flush_branch", 64'(flush_nop), 1);
        clear();
        rstn = 0;

        step(); idu_pc = 64'h100; set_alu(ALU_ADD, 0, 0, 10, 3, 1);
        #1 push(10, 64'h10A, 0, -1, 0);
        step(); idu_pc = 64'h104; set_alu(ALU_ADD, 3, 5, 1, 0, 1);
        mmu_wb_en = 1; mmu_index_rd = 3; mmu_wb_data = 20;
        #1 chk("fw1_ex_prio", 64'(fw_en1), 1); push(11, 64'h105, 0, -1, 0);
        step(); idu_pc = 64'h108; set_alu(ALU_ADD, 0, 5, 1, 0, 1);
        mmu_wb_en = 1; mmu_index_rd = 0; mmu_wb_data = 20;
        #1 chk("fw1_x0", 64'(fw_en1), 0); push(6, 64'h109, 0, -1, 0);
        step(); idu_pc = 64'h10C; set_alu(ALU_ADD, 9, 5, 1, 4, 1); idu_index_rs2 = 9;
        mmu_wb_en = 1; mmu_index_rd = 9; mmu_wb_data = 20;
        #1 chk("fw1_mem", 64'(fw_en1), 1); chk("fw2_mem", 64'(fw_en2), 1); push(21, 64'h10D, 20, -1, 0);
        step(); idu_pc = 64'h110; set_alu(ALU_ADD, 0, 64'h40, 8, 6, 1); idu_load_en = 1; idu_index_rs2 = 4;
        mmu_wb_en = 1; mmu_index_rd = 4; mmu_wb_data = 99;
        #1 chk("fw2_ex", 64'(fw_en2), 1); push(64'h48, 64'h118, 21, -1, 0);
        step(); idu_pc = 64'h114; set_alu(ALU_ADD, 6, 3, 0, 0, 0);
        #1 chk("fw1_load", 64'(fw_en1), 0); push(3, 64'h114, 0, -1, 0);
        step(); idu_pc = 64'h118; set_alu(ALU_ADD, 0, 64'h7FFFFFFF, 1, 0, 0); idu_alu_halfop = 1;
        #1 push(64'hFFFFFFFF80000000, 64'h119, 0, -1, 0);
        step(); idu_pc = 64'h11C; set_alu(ALU_SRA, 0, 64'h80000000, 4, 0, 0); idu_alu_halfop = 1;
        #1 push(64'hFFFFFFFFF8000000, 64'h120, 0, -1, 0);
        step(); idu_pc = 64'h120; set_alu(ALU_SRL, 0, 64'hFFFFFFFF80000000, 4, 0, 0); idu_alu_halfop = 1;
        #1 push(64'h08000000, 64'h124, 0, -1, 0);
        step(); idu_pc = 64'h124; set_alu(ALU_SUB, 0, 5, 0, 0, 0); idu_alu_imm_en = 0; idu_gpr_data2 = 7;
        #1 push(64'hFFFFFFFFFFFFFFFE, 64'h124, 7, -1, 0);
        step(); idu_pc = 64'h128; set_alu(ALU_SLL, 0, 1, 63, 0, 0);
        #1 push(64'h8000000000000000, 64'h167, 0, -1, 0);
        step(); idu_pc = 64'h12C; set_alu(ALU_PASSB, 0, 64'hDEAD, 64'h12345000, 0, 0);
        #1 push(64'h12345000, 64'h1234512C, 0, -1, 0);
        step(); idu_pc = 64'h130; set_alu(ALU_SRA, 0, 64'h8000000000000000, 63, 0, 0);
        #1 push(64'hFFFFFFFFFFFFFFFF, 64'h16F, 0, -1, 0);
        step(); idu_pc = 64'h134; set_alu(ALU_SLT, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0);
        #1 push(1, 64'h135, 0, -1, 0);
        step(); idu_pc = 64'h138; set_alu(ALU_SLTU, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0);
        #1 push(0, 64'h139, 0, -1, 0);
        step(); idu_pc = 64'h13C; set_alu(ALU_XOR, 0, 64'hF0, 64'hFF, 0, 0);
        #1 push(64'h0F, 64'h23B, 0, -1, 0);
        step(); idu_pc = 64'h140; set_alu(ALU_ADD, 0, 5, 1, 0, 0); idu_alu_en = 0;
        #1 push(0, 64'h141, 0, -1, 0);
        step(); idu_pc = 64'h1000; idu_index_rs1 = 1; idu_gpr_data1 = '1; idu_index_rs2 = 2; idu_gpr_data2 = 1;
        idu_imm = 64'h20; idu_branch_en = 1; idu_branch_opcode = BR_LT;
        #1 push(0, 64'h1020, 1, 1, 0);
        step(); idu_pc = 64'h1000; idu_index_rs1 = 1; idu_gpr_data1 = '1; idu_index_rs2 = 2; idu_gpr_data2 = 1;
        idu_imm = 64'h20; idu_branch_en = 1; idu_branch_opcode = BR_LTU;
        #1 push(0, 64'h1020, 1, 0, 0);
        step(); idu_pc = 64'h1004; idu_index_rs1 = 1; idu_gpr_data1 = 7; idu_index_rs2 = 2; idu_gpr_data2 = 7;
        idu_imm = 64'hFFFFFFFFFFFFFFF8; idu_branch_en = 1; idu_branch_opcode = BR_EQ;
        #1 push(0, 64'hFFC, 7, 1, 0);
        step(); idu_pc = 64'h3000; set_alu(ALU_ADD, 1, 64'h2001, 2, 1, 1); idu_jump_en = 1; idu_wb_choose = WB_LINK;
        #1 push(64'h2003, 64'h2002, 0, -1, 0);
        step(); idu_pc = 64'h2002; set_alu(ALU_ADD, 1, 0, 0, 0, 0);
        #1 chk("fw1_link", 64'(fw_en1), 1); push(64'h3004, 64'h2002, 0, -1, 0);
        step(); idu_pc = 64'h40; set_alu(ALU_ADD, 0, 1, 1, 5, 1); idu_store_en = 1; mmu_branch_en = 1;
        #1 chk("flush_req", 64'(flush_nop), 1); push(0, 0, 0, 0, 1);
        step(); idu_pc = 64'h50; set_alu(ALU_ADD, 0, 64'h10, 4, 0, 0); idu_store_en = 1; idu_gpr_data2 = 64'hAB;
        #1 push(64'h14, 64'h54, 64'hAB, -1, 0);
        step();
        repeat (4) @(posedge clk);
        #2 chk("scoreboard_drain", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
